uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among NREQ byte producers, for example the CPU console path, a debug monitor and the boot loader.
- Grants one requester at a time, round-robin.
- Writes the granted byte to UART register 0x00, then polls register 0x02 (transmit done) until the UART reports idle.
- Adds a guard gap before the next grant, and recovers from a hung UART via a poll timeout.
- Sits between the requesters and the UART's a/d/we/spo bus port, replacing direct bus writes.

---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART register map and arbiter state encoding for the pCPU UART TX sharing path.
package uart_tx_arbiter_pkg;

  localparam logic [2:0]  UART_REG_DATA   = 3'b000;
  localparam logic [2:0]  UART_REG_RXNEW  = 3'b001;
  localparam logic [2:0]  UART_REG_TXDONE = 3'b010;
  localparam int unsigned UART_TXDONE_BIT = 24;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned UART_DW         = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_POLL   = 3'd3,
    ST_GAP    = 3'd4
  } arb_state_t;

  // The UART takes the transmit byte in the top byte lane.
  function automatic logic [UART_DW-1:0] uart_wdata(input logic [BYTE_W-1:0] b);
    return {b, (UART_DW - BYTE_W)'(0)};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (ptr+1) mod N, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant_onehot,
  output logic [IW-1:0] o_grant_idx
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_found        = 1'b0;
    w_idx          = '0;
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = IW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found               = 1'b1;
        o_grant_onehot[w_idx] = 1'b1;
        o_grant_idx           = w_idx;
      end
    end
    if (!i_advance) begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte producers: round-robin grant,
// data write, TX-done polling with timeout, then a guard gap before the next grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    timeout_err,
  output logic [2:0]              uart_a,
  output logic [31:0]             uart_d,
  output logic                    uart_we,
  input  logic [31:0]             uart_spo
);

  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW    = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int unsigned GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam arb_state_t  ST_AFTER_TX = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t          r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_grant_id;
  logic [BYTE_W-1:0]   r_byte;
  logic [TW-1:0]       r_tcnt;
  logic [GW-1:0]       r_gcnt;
  logic                r_timeout_err;

  logic [NREQ-1:0]     w_grant_onehot;
  logic [IDW-1:0]      w_grant_idx;
  logic [BYTE_W-1:0]   w_byte;
  logic                w_advance;
  logic                w_tx_idle;
  logic                w_unused_spo;

  // Reset gates the accept pulse so ready drops the instant rst_n falls.
  assign w_advance = (r_state == ST_IDLE) && rst_n;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .i_req          (req_valid),
    .i_ptr          (r_ptr),
    .i_advance      (w_advance),
    .o_grant_onehot (w_grant_onehot),
    .o_grant_idx    (w_grant_idx)
  );

  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) w_byte = req_data[8*i +: 8];
    end
  end

  assign w_tx_idle    = uart_spo[UART_TXDONE_BIT];
  assign w_unused_spo = ^{uart_spo[31:UART_TXDONE_BIT+1], uart_spo[UART_TXDONE_BIT-1:0]};

  // Transfer sequencer; SETTLE skips the stale idle flag seen right after the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_byte        <= '0;
      r_tcnt        <= '0;
      r_gcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant_onehot) begin
            r_byte     <= w_byte;
            r_grant_id <= w_grant_idx;
            r_ptr      <= w_grant_idx;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_SETTLE;
        ST_SETTLE: begin
          r_tcnt  <= '0;
          r_state <= ST_POLL;
        end
        ST_POLL: begin
          if (w_tx_idle) begin
            r_gcnt  <= '0;
            r_state <= ST_AFTER_TX;
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_gcnt        <= '0;
            r_state       <= ST_AFTER_TX;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (r_gcnt == GW'(GLAST)) r_state <= ST_IDLE;
          else                      r_gcnt  <= r_gcnt + GW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = w_grant_onehot;
  assign busy        = (r_state != ST_IDLE);
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
  assign uart_we     = (r_state == ST_ISSUE);
  assign uart_a      = uart_we ? UART_REG_DATA : UART_REG_TXDONE;
  assign uart_d      = uart_we ? uart_wdata(r_byte) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 2-cycle guard, one with no guard.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_data, a_d, a_spo;
  logic        a_busy, a_toerr, a_we, a_idle;
  logic [1:0]  a_gid;
  logic [2:0]  a_a;

  logic [3:0]  b_valid, b_ready;
  logic [31:0] b_data, b_d, b_spo;
  logic        b_busy, b_toerr, b_we, b_idle;
  logic [1:0]  b_gid;
  logic [2:0]  b_a;

  int total = 0;
  int bad   = 0;
  int a_we_cnt = 0;
  int b_we_cnt = 0;
  int ord [5] = '{1, 2, 3, 0, 1};
  logic [31:0] exp_d;

  assign a_spo = {7'b0, a_idle, 24'h0};
  assign b_spo = {7'b0, b_idle, 24'h0};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .busy(a_busy), .grant_id(a_gid), .timeout_err(a_toerr), .uart_a(a_a), .uart_d(a_d),
    .uart_we(a_we), .uart_spo(a_spo)
  );

  uart_tx_arbiter #(.NREQ(4), .GUARD_CYCLES(0), .TIMEOUT_CYCLES(16)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .busy(b_busy), .grant_id(b_gid), .timeout_err(b_toerr), .uart_a(b_a), .uart_d(b_d),
    .uart_we(b_we), .uart_spo(b_spo)
  );

  always @(negedge clk) begin
    if (a_we) a_we_cnt++;
    if (b_we) b_we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 4'hF;
    a_data  = 32'h0;
    a_idle  = 1'b1;
    b_valid = 4'h0;
    b_data  = 32'h0;
    b_idle  = 1'b1;

    // Reset values, with requests pending to show ready is held off
    #3;
    chk("rst_busy",  32'(a_busy),  32'h0);
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_we",    32'(a_we),    32'h0);
    chk("rst_a",     32'(a_a),     32'h2);
    chk("rst_d",     a_d,          32'h0);
    chk("rst_gid",   32'(a_gid),   32'h0);
    chk("rst_toerr", 32'(a_toerr), 32'h0);
    cyc();
    cyc();
    rst_n   = 1'b1;
    a_valid = 4'h0;

    // Single requester 0, byte 0x41
    a_valid = 4'h1;
    a_data  = 32'h41;
    #1 chk("t1_ready", 32'(a_ready), 32'h1);
    cyc();
    a_valid = 4'h0;
    a_idle  = 1'b0;
    #1;
    chk("t1_we",   32'(a_we),   32'h1);
    chk("t1_a",    32'(a_a),    32'h0);
    chk("t1_d",    a_d,         32'h4100_0000);
    chk("t1_busy", 32'(a_busy), 32'h1);
    chk("t1_ready_issue", 32'(a_ready), 32'h0);
    cyc();
    #1;
    chk("t1_settle_we", 32'(a_we), 32'h0);
    chk("t1_settle_a",  32'(a_a),  32'h2);
    cyc();
    repeat (5) cyc();
    a_idle = 1'b1;
    cyc();
    cyc();
    #1 chk("t1_gap_busy", 32'(a_busy), 32'h1);
    cyc();
    #1 chk("t1_idle_busy", 32'(a_busy), 32'h0);

    // Requesters 0 and 2 together: 2 wins first from ptr=0
    a_valid = 4'h5;
    a_data  = 32'h00BB_00AA;
    #1 chk("t2_ready_first", 32'(a_ready), 32'h4);
    cyc();
    a_valid = 4'h1;
    #1;
    chk("t2_d_first",   a_d,          32'hBB00_0000);
    chk("t2_gid_first", 32'(a_gid),   32'h2);
    chk("t2_ready_hold", 32'(a_ready), 32'h0);
    repeat (5) cyc();
    #1;
    chk("t2_ready_second", 32'(a_ready), 32'h1);
    chk("t2_busy_idle",    32'(a_busy),  32'h0);
    cyc();
    a_valid = 4'h0;
    #1;
    chk("t2_d_second",   a_d,        32'hAA00_0000);
    chk("t2_gid_second", 32'(a_gid), 32'h0);
    repeat (5) cyc();

    // All four valid continuously: order 1,2,3,0,1
    a_valid = 4'hF;
    a_data  = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_ready", 32'(a_ready), 32'h1 << ord[i]);
      cyc();
      if (i == 4) a_valid = 4'h0;
      exp_d = {8'h10 + 8'(ord[i]), 24'h0};
      #1;
      chk("t3_we",      32'(a_we),    32'h1);
      chk("t3_gid",     32'(a_gid),   32'(ord[i]));
      chk("t3_d",       a_d,          exp_d);
      chk("t3_no_ovl",  32'(a_ready), 32'h0);
      repeat (5) cyc();
    end

    // Poll timeout with TX-idle stuck low, then a normal transfer
    a_idle  = 1'b0;
    a_valid = 4'h8;
    a_data  = 32'h7700_0000;
    #1 chk("t4_ready", 32'(a_ready), 32'h8);
    cyc();
    a_valid = 4'h0;
    cyc();
    cyc();
    repeat (15) cyc();
    #1;
    chk("t4_toerr_early", 32'(a_toerr), 32'h0);
    chk("t4_busy_poll",   32'(a_busy),  32'h1);
    cyc();
    #1 chk("t4_toerr_pulse", 32'(a_toerr), 32'h1);
    cyc();
    #1 chk("t4_toerr_drop", 32'(a_toerr), 32'h0);
    cyc();
    #1 chk("t4_idle_busy", 32'(a_busy), 32'h0);
    a_idle  = 1'b1;
    a_valid = 4'h1;
    a_data  = 32'h0000_005A;
    #1 chk("t4_ready_next", 32'(a_ready), 32'h1);
    cyc();
    a_valid = 4'h0;
    #1;
    chk("t4_we_next", 32'(a_we), 32'h1);
    chk("t4_d_next",  a_d,       32'h5A00_0000);
    repeat (5) cyc();

    // Asynchronous reset during POLL, then re-grant from ptr=0
    a_idle  = 1'b0;
    a_valid = 4'h4;
    a_data  = 32'h0033_4400;
    #1 chk("t5_ready", 32'(a_ready), 32'h4);
    cyc();
    a_valid = 4'h3;
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy",  32'(a_busy),  32'h0);
    chk("t5_rst_we",    32'(a_we),    32'h0);
    chk("t5_rst_ready", 32'(a_ready), 32'h0);
    chk("t5_rst_a",     32'(a_a),     32'h2);
    chk("t5_rst_gid",   32'(a_gid),   32'h0);
    cyc();
    rst_n = 1'b1;
    #1 chk("t5_ready_after", 32'(a_ready), 32'h2);
    cyc();
    a_valid = 4'h0;
    a_idle  = 1'b1;
    #1;
    chk("t5_gid_after", 32'(a_gid), 32'h1);
    chk("t5_d_after",   a_d,        32'h4400_0000);
    repeat (5) cyc();

    // No guard gap: requester 3 sends 0x01 then 0x02 back to back
    b_valid = 4'h8;
    b_data  = 32'h0100_0000;
    #1 chk("t6_ready_first", 32'(b_ready), 32'h8);
    cyc();
    b_data = 32'h0200_0000;
    b_idle = 1'b0;
    #1;
    chk("t6_we_first",  32'(b_we),    32'h1);
    chk("t6_d_first",   b_d,          32'h0100_0000);
    chk("t6_ready_hold", 32'(b_ready), 32'h0);
    cyc();
    cyc();
    #1;
    chk("t6_poll_we",    32'(b_we),    32'h0);
    chk("t6_poll_ready", 32'(b_ready), 32'h0);
    b_idle = 1'b1;
    cyc();
    #1;
    chk("t6_ready_second", 32'(b_ready), 32'h8);
    chk("t6_busy_idle",    32'(b_busy),  32'h0);
    cyc();
    b_valid = 4'h0;
    #1;
    chk("t6_we_second", 32'(b_we), 32'h1);
    chk("t6_d_second",  b_d,       32'h0200_0000);
    cyc();
    cyc();
    cyc();
    #1;
    chk("t6_busy_end", 32'(b_busy), 32'h0);
    chk("b_we_count",  32'(b_we_cnt), 32'h2);
    chk("a_we_count",  32'(a_we_cnt), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
